// File: rtl/ysyx_22050039_pkg.sv
// Shared fetch-path definitions: datapath widths, boot PC and the fetch-queue entry layout.
package ysyx_22050039_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            alloc;
    logic            filled;
  } ifq_entry_t;

endpackage

// File: rtl/ysyx_22050039_ifq.sv
// Instruction fetch queue: issues in-order fetches, pairs returned words with their PC in a
// ring buffer and hands {pc, inst} to decode; a flush drops everything queued or in flight.
module ysyx_22050039_ifq
  import ysyx_22050039_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_adv,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [ILEN-1:0] resp_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ifq_entry_t       entry_reg [DEPTH];
  ifq_entry_t       head;
  logic [PW-1:0]    alloc_ptr_reg;
  logic [PW-1:0]    fill_ptr_reg;
  logic [PW-1:0]    head_ptr_reg;
  logic [CW-1:0]    used_reg;
  logic [CW-1:0]    drop_cnt_reg;
  logic [CW-1:0]    unfilled_cnt;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_cnt_flush;
  logic [DEPTH-1:0] alloc_sel;
  logic [DEPTH-1:0] fill_sel;
  logic [DEPTH-1:0] deq_sel;
  logic [DEPTH-1:0] pending_vec;
  logic             resp_fill;
  logic             resp_drop;
  logic             deq;

  assign head      = entry_reg[head_ptr_reg];
  assign req_valid = rst & ~flush & (used_reg < CW'(DEPTH)) & (drop_cnt_reg == '0);
  assign fetch_adv = req_valid & req_ready;
  assign req_addr  = fetch_pc;
  assign out_valid = rst & ~flush & head.filled;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign deq       = out_valid & out_ready;
  assign resp_fill = resp_valid & ~flush & (drop_cnt_reg == '0);
  assign resp_drop = resp_valid & ~flush & (drop_cnt_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign alloc_sel[gi]   = fetch_adv & (alloc_ptr_reg == PW'(gi));
      assign fill_sel[gi]    = resp_fill & (fill_ptr_reg == PW'(gi));
      assign deq_sel[gi]     = deq & (head_ptr_reg == PW'(gi));
      assign pending_vec[gi] = entry_reg[gi].alloc & ~entry_reg[gi].filled;
    end
  endgenerate

  always_comb begin
    unfilled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      unfilled_cnt = unfilled_cnt + CW'(pending_vec[i]);
    end
  end

  // Every request still owed a word after the flush must be swallowed; a word arriving in
  // the flush cycle itself settles one of them.
  assign outstanding    = drop_cnt_reg + unfilled_cnt;
  assign drop_cnt_flush = (resp_valid && outstanding != '0) ? outstanding - CW'(1) : outstanding;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i].alloc  <= 1'b0;
        entry_reg[i].filled <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (deq_sel[i]) begin
          entry_reg[i].alloc  <= 1'b0;
          entry_reg[i].filled <= 1'b0;
        end
        if (fill_sel[i]) begin
          entry_reg[i].inst   <= resp_data;
          entry_reg[i].filled <= 1'b1;
        end
        if (alloc_sel[i]) begin
          entry_reg[i].pc     <= fetch_pc;
          entry_reg[i].alloc  <= 1'b1;
          entry_reg[i].filled <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      used_reg      <= '0;
      drop_cnt_reg  <= '0;
    end else if (flush) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      head_ptr_reg  <= '0;
      used_reg      <= '0;
      drop_cnt_reg  <= drop_cnt_flush;
    end else begin
      if (fetch_adv) alloc_ptr_reg <= alloc_ptr_reg + PW'(1);
      if (resp_fill) fill_ptr_reg <= fill_ptr_reg + PW'(1);
      if (deq) head_ptr_reg <= head_ptr_reg + PW'(1);
      if (fetch_adv && !deq) begin
        used_reg <= used_reg + CW'(1);
      end else if (deq && !fetch_adv) begin
        used_reg <= used_reg - CW'(1);
      end
      if (resp_drop) drop_cnt_reg <= drop_cnt_reg - CW'(1);
    end
  end

  // A returned word must belong to a live or to-be-dropped request.
  a_resp_has_owner : assert property (@(posedge clk) disable iff (!rst)
    resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ysyx_22050039_ifq.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-level model
// of the fetch queue and a variable-latency in-order instruction memory.
module tb_ysyx_22050039_ifq;
  import ysyx_22050039_pkg::*;

  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            fetch_adv;
  logic            req_valid;
  logic            req_ready = 1'b0;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid = 1'b0;
  logic [ILEN-1:0] resp_data = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_inst;

  always #5 clk = ~clk;

  ysyx_22050039_ifq #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_pc   (fetch_pc),
    .fetch_adv  (fetch_adv),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    bit              filled;
  } mitem_t;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mreq_t;

  mitem_t          m_q[$];
  mreq_t           mem_q[$];
  int              m_drop = 0;
  int              cyc = 0;
  int              lat_min = 1;
  int              lat_max = 1;
  int              last_due = 0;
  int              issued = 0;
  int              out_cnt = 0;
  int              first_out_cyc = -1;
  int              tests = 0;
  int              fails = 0;
  logic [XLEN-1:0] ifu_pc = RESET_PC;
  logic [XLEN-1:0] first_out_pc = '0;
  logic [XLEN-1:0] last_out_pc = '0;

  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_model();
    m_q.delete();
    mem_q.delete();
    m_drop = 0;
    last_due = 0;
  endtask

  task automatic clear_stats();
    out_cnt = 0;
    first_out_cyc = -1;
    issued = 0;
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, advance models at the rising edge.
  task automatic cycle(input bit fl, input bit ordy, input bit rrdy, input logic [XLEN-1:0] target);
    bit     erv;
    bit     eov;
    bit     rv_in;
    int     unf;
    int     due;
    mitem_t it;
    flush     = fl;
    out_ready = ordy;
    req_ready = rrdy;
    fetch_pc  = ifu_pc;
    rv_in     = rst && mem_q.size() > 0 && mem_q[0].due <= cyc;
    resp_valid = rv_in;
    resp_data  = rv_in ? mem_word(mem_q[0].addr) : '0;
    #1;
    erv = rst && !fl && m_q.size() < DEPTH && m_drop == 0;
    eov = rst && !fl && m_q.size() > 0 && m_q[0].filled;
    check("req_valid", 64'(req_valid), 64'(erv));
    check("fetch_adv", 64'(fetch_adv), 64'(erv && rrdy));
    check("out_valid", 64'(out_valid), 64'(eov));
    if (erv) check("req_addr", req_addr, ifu_pc);
    if (eov) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_inst", 64'(out_inst), 64'(m_q[0].inst));
    end
    if (!rst) begin
      check("rst_out_pc", out_pc, '0);
      check("rst_out_inst", 64'(out_inst), '0);
    end
    if (out_valid && ordy) begin
      if (first_out_cyc < 0) begin
        first_out_cyc = cyc;
        first_out_pc  = out_pc;
      end
      last_out_pc = out_pc;
      out_cnt++;
    end
    @(posedge clk);
    if (rv_in) void'(mem_q.pop_front());
    if (req_valid && rrdy) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: req_addr, due: due});
    end
    if (!rst) begin
      reset_model();
    end else if (fl) begin
      unf = 0;
      foreach (m_q[i]) if (!m_q[i].filled) unf++;
      m_drop = m_drop + unf - (rv_in ? 1 : 0);
      if (m_drop < 0) m_drop = 0;
      m_q.delete();
    end else begin
      if (rv_in) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          for (int i = 0; i < m_q.size(); i++) begin
            if (!m_q[i].filled) begin
              it = m_q[i];
              it.filled = 1'b1;
              it.inst = mem_word(it.pc);
              m_q[i] = it;
              break;
            end
          end
        end
      end
      if (eov && ordy) void'(m_q.pop_front());
      if (erv && rrdy) begin
        m_q.push_back('{pc: ifu_pc, inst: '0, filled: 1'b0});
        issued++;
      end
    end
    if (fl) ifu_pc = target;
    else if (rst && erv && rrdy) ifu_pc = ifu_pc + 64'd4;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_q.size() > 0 || mem_q.size() > 0 || m_drop > 0) && n < 60) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      n++;
    end
    check("drain_done", 64'(m_q.size() + mem_q.size() + m_drop), '0);
  endtask

  initial begin
    int start;
    logic [XLEN-1:0] tgt;
    @(negedge clk);
    // Reset held: everything quiet and zero.
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, '0);

    // Release, 1-cycle memory, stream of 8 fetches.
    rst = 1'b1;
    clear_stats();
    start = cyc;
    for (int i = 0; i < 40 && out_cnt < 8; i++) cycle(1'b0, 1'b1, issued < 8, '0);
    check("first_latency", 64'(first_out_cyc - start), 64'd2);
    check("first_pc", first_out_pc, RESET_PC);
    check("stream_count", 64'(out_cnt), 64'd8);
    check("stream_last_pc", last_out_pc, RESET_PC + 64'd28);
    drain();

    // Back-pressure: decode stalls for 5 cycles while IFU keeps asking.
    clear_stats();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    check("stall_issued", 64'(issued), 64'(DEPTH));
    for (int i = 0; i < 10 && out_cnt < 2; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    check("stall_release_cnt", 64'(out_cnt), 64'd2);
    drain();

    // Flush with two requests in flight on a 3-cycle memory.
    lat_min = 3;
    lat_max = 3;
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b0, RESET_PC + 64'h100);
    check("flush_drop_cnt", 64'(m_drop), 64'd2);
    clear_stats();
    for (int i = 0; i < 20 && first_out_cyc < 0; i++) cycle(1'b0, 1'b1, 1'b1, '0);
    check("post_flush_pc", first_out_pc, RESET_PC + 64'h100);
    drain();

    // Flush coinciding with a response and a would-be dequeue.
    lat_min = 1;
    lat_max = 1;
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, '0);
    clear_stats();
    cycle(1'b1, 1'b1, 1'b0, RESET_PC + 64'h200);
    check("flush_no_deq", 64'(out_cnt), 64'd0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    drain();

    // Asynchronous reset between acceptance and response.
    lat_min = 2;
    lat_max = 2;
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    rst = 1'b0;
    #1;
    check("async_req_valid", 64'(req_valid), '0);
    check("async_fetch_adv", 64'(fetch_adv), '0);
    check("async_out_valid", 64'(out_valid), '0);
    check("async_out_pc", out_pc, '0);
    check("async_out_inst", 64'(out_inst), '0);
    reset_model();
    @(negedge clk);
    cycle(1'b0, 1'b1, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b1, '0);
    rst = 1'b1;
    clear_stats();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    check("post_reset_no_out", 64'(out_cnt), '0);

    // Random traffic with variable latency and occasional redirects.
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      tgt = RESET_PC + 64'($urandom_range(0, 255)) * 64'd16;
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, tgt);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
